// File: rtl/uart_tx_param.sv
// UART transmitter with a DEPTH-word input FIFO; frames are start, DATA_BITS LSB-first,
// optional parity and 1 or 2 stop bits, sent back-to-back while words are queued.
module uart_tx_param #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         serial_out,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned Cpb    = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW   = $clog2(Cpb);
  localparam int unsigned IdxW   = $clog2(DATA_BITS);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  localparam logic [CntW-1:0]   CntMax    = CntW'(Cpb - 1);
  localparam logic [IdxW-1:0]   IdxMax    = IdxW'(DATA_BITS - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(DEPTH);
  localparam bit                HasParity = (PARITY_MODE != 0);
  localparam bit                OddParity = (PARITY_MODE == 2);
  localparam logic              LastStop  = (STOP_BITS == 2);

  if (Cpb < 2) begin : gen_bad_cpb
    $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE > 2) begin : gen_bad_parity
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("uart_tx_param: DEPTH must be a power of 2, >= 2");
  end

  // ---------------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0]    count_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (count_q != CountFull);
  assign push       = tx_valid & tx_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CountW'(1);
        2'b01:   count_q <= count_q - CountW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic                 bit_end;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    pop     = 1'b0;
    bit_end = (cnt_q == CntMax);
    cnt_d   = (state_q == StIdle || bit_end) ? '0 : cnt_q + CntW'(1);

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ OddParity;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IdxMax) begin
            stop_d  = 1'b0;
            state_d = HasParity ? StParity : StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          stop_d  = 1'b0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_q == LastStop) begin
            // Chain straight into the next frame when a word is waiting.
            if (count_q != '0) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ OddParity;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    serial_out = 1'b1;
    unique case (state_q)
      StStart:  serial_out = 1'b0;
      StData:   serial_out = shift_q[0];
      StParity: serial_out = par_q;
      default:  serial_out = 1'b1;
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: directed frame table over four parameter sets, plus a cycle-exact
// line/handshake reference model driving one even-parity instance with random traffic.
module tb_uart_tx_param;

  localparam int CF   = 1_000_000;
  localparam int BR   = 100_000;
  localparam int MAXC = 8192;
  localparam int FLEN = 110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Model-checked instance: even parity, 8 data bits, 1 stop.
  logic       rst_a, valid_a, ready_a, line_a, busy_a;
  logic [7:0] data_a;
  logic [2:0] cnt_a;
  // Directed instances.
  logic       rst_o;
  logic       valid_e, ready_e, line_e, busy_e;
  logic       valid_b, ready_b, line_b, busy_b;
  logic       valid_c, ready_c, line_c, busy_c;
  logic       valid_d, ready_d, line_d, busy_d;
  logic [7:0] data_e, data_b, data_c;
  logic [6:0] data_d;
  logic [2:0] cnt_e, cnt_b, cnt_c, cnt_d;

  uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
    .DEPTH(4)) u_model (.clk(clk), .rst(rst_a), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .serial_out(line_a), .busy(busy_a), .fifo_count(cnt_a));
  uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
    .DEPTH(4)) u_even (.clk(clk), .rst(rst_o), .tx_data(data_e), .tx_valid(valid_e),
    .tx_ready(ready_e), .serial_out(line_e), .busy(busy_e), .fifo_count(cnt_e));
  uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
    .DEPTH(4)) u_odd (.clk(clk), .rst(rst_o), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .serial_out(line_b), .busy(busy_b), .fifo_count(cnt_b));
  uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2),
    .DEPTH(4)) u_none2 (.clk(clk), .rst(rst_o), .tx_data(data_c), .tx_valid(valid_c),
    .tx_ready(ready_c), .serial_out(line_c), .busy(busy_c), .fifo_count(cnt_c));
  uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1),
    .DEPTH(4)) u_d7 (.clk(clk), .rst(rst_o), .tx_data(data_d), .tx_valid(valid_d),
    .tx_ready(ready_d), .serial_out(line_d), .busy(busy_d), .fifo_count(cnt_d));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------------------------
  // Directed frames: bits[k] is the expected line level for 10-clock slot k.
  // ---------------------------------------------------------------------------------------------
  typedef struct {
    int         sel;
    logic [8:0] data;
    logic [11:0] bits;
    int         nslots;
    int         flen;
  } vec_t;

  vec_t vecs [6];

  task automatic set_in(input int sel, input logic v, input logic [8:0] d);
    case (sel)
      1: begin valid_e = v; data_e = d[7:0]; end
      2: begin valid_b = v; data_b = d[7:0]; end
      3: begin valid_c = v; data_c = d[7:0]; end
      default: begin valid_d = v; data_d = d[6:0]; end
    endcase
  endtask

  function automatic logic get_line(input int sel);
    case (sel)
      1: return line_e;
      2: return line_b;
      3: return line_c;
      default: return line_d;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1: return busy_e;
      2: return busy_b;
      3: return busy_c;
      default: return busy_d;
    endcase
  endfunction

  task automatic run_vec(input vec_t v);
    logic lb [0:159];
    logic bb [0:159];
    int   nbusy, first, lows, match;
    set_in(v.sel, 1'b1, v.data);
    @(negedge clk);
    set_in(v.sel, 1'b0, 9'h0);
    // Sample c is taken after push edge + c.
    for (int c = 0; c < v.flen + 20; c++) begin
      lb[c] = get_line(v.sel);
      bb[c] = get_busy(v.sel);
      @(negedge clk);
    end
    chk("vec_idle_after_push", {30'd0, lb[0], bb[0]}, 32'd2);
    for (int k = 0; k < v.nslots; k++) begin
      match = 0;
      for (int j = 0; j < 10; j++) if (lb[1 + 10 * k + j] === v.bits[k]) match++;
      chk($sformatf("vec_sel%0d_slot%0d", v.sel, k), match, 10);
    end
    nbusy = 0; first = -1; lows = 0;
    for (int c = 0; c < v.flen + 20; c++) begin
      if (bb[c] === 1'b1) begin
        nbusy++;
        if (first < 0) first = c;
      end
      if (c > v.flen && lb[c] !== 1'b1) lows++;
    end
    chk("vec_busy_len", nbusy, v.flen);
    chk("vec_busy_start", first, 1);
    chk("vec_line_idle_after", lows, 0);
  endtask

  // ---------------------------------------------------------------------------------------------
  // Reference model for u_model: each accepted word owns a 110-clock window starting at
  // max(push edge + 1, end of previous window); it sits in the FIFO until that start edge.
  // ---------------------------------------------------------------------------------------------
  bit exp_line [MAXC];
  bit exp_busy [MAXC];
  int starts [$];
  int next_free;
  int t;

  function automatic bit fbit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic step_a(input bit r, input bit v, input logic [7:0] d, output bit acc);
    int s;
    while (starts.size() > 0 && starts[0] <= t) void'(starts.pop_front());
    chk("m_line", line_a, exp_line[t]);
    chk("m_busy", busy_a, exp_busy[t]);
    chk("m_ready", ready_a, starts.size() != 4);
    chk("m_count", cnt_a, starts.size());
    rst_a = r; valid_a = v; data_a = d; acc = 1'b0;
    if (r) begin
      for (int i = t + 1; i < next_free; i++) begin exp_line[i] = 1'b1; exp_busy[i] = 1'b0; end
      starts.delete();
      next_free = 0;
    end else if (v && starts.size() != 4) begin
      acc = 1'b1;
      s = (t + 2 > next_free) ? t + 2 : next_free;
      if (s + FLEN >= MAXC) begin
        $display("FAIL model_overflow: got cycle %0d, expected below %0d", s + FLEN, MAXC);
        $fatal(1);
      end
      for (int k = 0; k < FLEN; k++) begin
        exp_line[s + k] = fbit(d, k / 10);
        exp_busy[s + k] = 1'b1;
      end
      starts.push_back(s);
      next_free = s + FLEN;
    end
    @(negedge clk);
    t++;
  endtask

  bit         acc;
  int         t0, n_acc, nb, pct;
  logic [7:0] dd;

  task automatic drain();
    bit a;
    for (int i = 0; i < 1000 && t < next_free + 2; i++) step_a(1'b0, 1'b0, 8'h00, a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MAXC; i++) begin exp_line[i] = 1'b1; exp_busy[i] = 1'b0; end
    vecs[0] = '{sel: 1, data: 9'h0A5, bits: 12'h54A, nslots: 11, flen: 110};
    vecs[1] = '{sel: 2, data: 9'h007, bits: 12'h40E, nslots: 11, flen: 110};
    vecs[2] = '{sel: 1, data: 9'h007, bits: 12'h60E, nslots: 11, flen: 110};
    vecs[3] = '{sel: 3, data: 9'h000, bits: 12'h600, nslots: 11, flen: 110};
    vecs[4] = '{sel: 4, data: 9'h055, bits: 12'h2AA, nslots: 10, flen: 100};
    vecs[5] = '{sel: 2, data: 9'h0A5, bits: 12'h74A, nslots: 11, flen: 110};

    rst_a = 1'b1; rst_o = 1'b1;
    valid_a = 1'b0; valid_e = 1'b0; valid_b = 1'b0; valid_c = 1'b0; valid_d = 1'b0;
    data_a = '0; data_e = '0; data_b = '0; data_c = '0; data_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_line", line_e, 1);
    chk("reset_busy", busy_e, 0);
    chk("reset_ready", ready_e, 1);
    chk("reset_count", cnt_e, 0);
    rst_o = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Model run starts at t = 0: u_model has just seen a reset edge.
    t = 0; next_free = 0;

    // Valid held with incrementing data: 5 accepted, then stall until the first stop ends.
    t0 = t; n_acc = 0; dd = 8'h10;
    for (int i = 0; i < 200 && n_acc < 6; i++) begin
      step_a(1'b0, 1'b1, dd, acc);
      if (acc) begin n_acc++; dd++; end
      if (t == t0 + 5)   begin chk("fill_count", cnt_a, 4); chk("fill_ready", ready_a, 0); end
      if (t == t0 + 111) chk("stall_ready", ready_a, 0);
      if (t == t0 + 112) begin chk("reopen_ready", ready_a, 1); chk("reopen_count", cnt_a, 3); end
    end
    drain();

    // Reset during data bit 3 with two words queued.
    t0 = t;
    step_a(1'b0, 1'b1, 8'h3C, acc);
    step_a(1'b0, 1'b1, 8'hC3, acc);
    step_a(1'b0, 1'b1, 8'h5A, acc);
    for (int i = 0; i < 100 && t < t0 + 46; i++) step_a(1'b0, 1'b0, 8'h00, acc);
    chk("pre_reset_queued", cnt_a, 2);
    step_a(1'b1, 1'b0, 8'h00, acc);
    chk("rst_line", line_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_ready", ready_a, 1);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      step_a(1'b0, 1'b0, 8'h00, acc);
      if (busy_a !== 1'b0) nb++;
    end
    chk("post_reset_busy_cycles", nb, 0);

    // Random traffic in phases of differing load, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      pct = (i < 1000) ? 5 : (i < 2000) ? 40 : 95;
      step_a($urandom_range(0, 799) == 0, $urandom_range(0, 99) < pct, 8'($urandom), acc);
    end
    drain();
    step_a(1'b0, 1'b0, 8'h00, acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
